// File: rtl/clb_pkg.sv
// Shared types and field widths for the clb_cluster configurable logic block.
package clb_pkg;

  localparam int SIGNAL_TYPE_W  = 2;
  localparam int SIGNAL_INDEX_W = 8;
  localparam int SRC_SPACE      = 2 ** SIGNAL_INDEX_W;
  localparam int CNT_W          = 7;

  typedef enum logic [SIGNAL_TYPE_W-1:0] {
    NEIGHBOUR = 2'd0,
    IO        = 2'd1,
    FEEDBACK  = 2'd2,
    CONST0    = 2'd3
  } t_input_type;

  typedef enum logic [2:0] {
    UNCFG,
    READ_TYPE,
    READ_INDEX,
    READ_TT,
    READ_MODE,
    CONFIGURED,
    ERROR
  } t_clb_state;

  function automatic logic is_read_state(input t_clb_state s);
    return (s == READ_TYPE) || (s == READ_INDEX) || (s == READ_TT) || (s == READ_MODE);
  endfunction

endpackage

// File: rtl/axi_stream_if.sv
// Minimal AXI-Stream bundle used by the tile configuration chain.
interface axi_stream_if #(
  parameter int DATA_W = 8
) ();
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/clb_lut_lane.sv
// One LUT lane: config registers, per-input source mux, truth table, q register.
// Output register select exists only when CLB_OUTPUT_FF_EN is defined.
import clb_pkg::*;

module clb_lut_lane #(
  parameter int NUM_LUTS              = 2,
  parameter int LUT_WIDTH             = 4,
  parameter int NUM_NEIGHBOUR_SIGNALS = 8,
  parameter int NUM_IO_SIGNALS        = 4,
  parameter int INP_W                 = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clr,
  input  logic                             sel,
  input  logic                             type_we,
  input  logic                             idx_we,
  input  logic                             tt_we,
  input  logic                             mode_we,
  input  logic [INP_W-1:0]                 wr_inp,
  input  logic [SIGNAL_INDEX_W-1:0]        wr_val,
  input  logic [LUT_WIDTH-1:0]             tt_addr,
  input  logic                             wr_bit,
  input  logic                             run_en,
  input  logic [NUM_NEIGHBOUR_SIGNALS-1:0] neighbours,
  input  logic [NUM_IO_SIGNALS-1:0]        io,
  input  logic [NUM_LUTS-1:0]              fb,
  output logic                             q,
  output logic                             lane_out
);

  localparam int TT_BITS = 2 ** LUT_WIDTH;
  localparam logic [LUT_WIDTH-1:0][SIGNAL_TYPE_W-1:0] TYPES_RST =
    {LUT_WIDTH{SIGNAL_TYPE_W'(CONST0)}};

  logic [LUT_WIDTH-1:0][SIGNAL_TYPE_W-1:0]  type_q, type_d;
  logic [LUT_WIDTH-1:0][SIGNAL_INDEX_W-1:0] idx_q, idx_d;
  logic [TT_BITS-1:0]                       tt_q, tt_d;
  logic                                     mode_q, mode_d;
  logic                                     q_q, q_d;
  logic [LUT_WIDTH-1:0]                     lut_in;
  logic                                     f;

  // Sources zero-extended to the full index space: an out-of-range index reads 0.
  logic [SRC_SPACE-1:0] nb_ext, io_ext, fb_ext;
  assign nb_ext = SRC_SPACE'(neighbours);
  assign io_ext = SRC_SPACE'(io);
  assign fb_ext = SRC_SPACE'(fb);

  for (genvar gi = 0; gi < LUT_WIDTH; gi++) begin : g_in
    assign lut_in[gi] =
      (t_input_type'(type_q[gi]) == NEIGHBOUR) ? nb_ext[idx_q[gi]] :
      (t_input_type'(type_q[gi]) == IO)        ? io_ext[idx_q[gi]] :
      (t_input_type'(type_q[gi]) == FEEDBACK)  ? fb_ext[idx_q[gi]] : 1'b0;
  end

  assign f = tt_q[lut_in];
  assign q = q_q;

`ifdef CLB_OUTPUT_FF_EN
  assign lane_out = mode_q ? q_q : f;
`else
  logic unused_mode;
  assign unused_mode = mode_q;
  assign lane_out    = f;
`endif

  always_comb begin
    type_d = type_q;
    idx_d  = idx_q;
    tt_d   = tt_q;
    mode_d = mode_q;
    q_d    = q_q;
    if (clr) begin
      type_d = TYPES_RST;
      idx_d  = '0;
      tt_d   = '0;
      mode_d = 1'b0;
      q_d    = 1'b0;
    end else begin
      if (sel && type_we) type_d[wr_inp] = wr_val[SIGNAL_TYPE_W-1:0];
      if (sel && idx_we)  idx_d[wr_inp]  = wr_val;
      if (sel && tt_we)   tt_d[tt_addr]  = wr_bit;
      if (sel && mode_we) mode_d         = wr_bit;
      if (run_en)         q_d            = f;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_q <= TYPES_RST;
      idx_q  <= '0;
      tt_q   <= '0;
      mode_q <= 1'b0;
      q_q    <= 1'b0;
    end else begin
      type_q <= type_d;
      idx_q  <= idx_d;
      tt_q   <= tt_d;
      mode_q <= mode_d;
      q_q    <= q_d;
    end
  end

endmodule

// File: rtl/clb_cluster.sv
// Cluster of LUT lanes loaded bit-serially from one AXI-Stream config chain.
// Optional per-lane output register: define CLB_OUTPUT_FF_EN.
import clb_pkg::*;

module clb_cluster #(
  parameter int NUM_LUTS              = 2,
  parameter int LUT_WIDTH             = 4,
  parameter int NUM_NEIGHBOUR_SIGNALS = 8,
  parameter int NUM_IO_SIGNALS        = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             cfg,
  axi_stream_if.slave                      cfg_bitstream,
  input  logic                             run,
  input  logic [NUM_NEIGHBOUR_SIGNALS-1:0] run_in_neighbours,
  input  logic [NUM_IO_SIGNALS-1:0]        run_in_io,
  output logic [NUM_LUTS-1:0]              run_out,
  output logic                             cfg_done,
  output logic                             cfg_error
);

  localparam int TT_BITS   = 2 ** LUT_WIDTH;
  localparam int LANE_W    = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
  localparam int INP_W     = (LUT_WIDTH > 1) ? $clog2(LUT_WIDTH) : 1;
  localparam int FSEL_W    = $clog2(SIGNAL_INDEX_W);
  localparam int LIM_W     = SIGNAL_INDEX_W + 1;

  t_clb_state                 state_q, state_d;
  logic [CNT_W-1:0]           bit_cnt_q, bit_cnt_d;
  logic [LANE_W-1:0]          lane_q, lane_d;
  logic [INP_W-1:0]           inp_q, inp_d;
  logic [SIGNAL_INDEX_W-1:0]  field_q, field_d, field_val;
  t_input_type                cur_type_q, cur_type_d;
  logic                       cfg_error_q, cfg_error_d;

  logic beat, bit_in, tready;
  logic type_we, idx_we, tt_we, mode_we, clr;
  logic lane_end, last_bit;
  logic [NUM_LUTS-1:0] q_all, lane_out;

  logic unused_tdata;
  assign unused_tdata = ^cfg_bitstream.tdata;

  assign tready              = is_read_state(state_q);
  assign cfg_bitstream.tready = tready;
  assign beat                = tready & cfg_bitstream.tvalid;
  assign bit_in              = cfg_bitstream.tdata[0];
  assign cfg_done            = (state_q == CONFIGURED);
  assign cfg_error           = cfg_error_q;
  assign run_out             = cfg_done ? lane_out : '0;

  function automatic logic idx_out_of_range(input t_input_type t,
                                            input logic [SIGNAL_INDEX_W-1:0] idx);
    logic [LIM_W-1:0] lim;
    case (t)
      NEIGHBOUR: lim = LIM_W'(NUM_NEIGHBOUR_SIGNALS);
      IO:        lim = LIM_W'(NUM_IO_SIGNALS);
      FEEDBACK:  lim = LIM_W'(NUM_LUTS);
      default:   return 1'b0;
    endcase
    return {1'b0, idx} >= lim;
  endfunction

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    lane_d      = lane_q;
    inp_d       = inp_q;
    field_d     = field_q;
    cur_type_d  = cur_type_q;
    cfg_error_d = cfg_error_q;
    type_we     = 1'b0;
    idx_we      = 1'b0;
    tt_we       = 1'b0;
    mode_we     = 1'b0;
    clr         = 1'b0;
    lane_end    = 1'b0;
    last_bit    = 1'b0;
    // Field value including the bit arriving this cycle (fields are LSB first).
    field_val                         = field_q;
    field_val[bit_cnt_q[FSEL_W-1:0]]  = bit_in;

    case (state_q)
      UNCFG, CONFIGURED, ERROR: begin
        if (cfg) begin
          clr         = (state_q != UNCFG);
          state_d     = READ_TYPE;
          bit_cnt_d   = '0;
          lane_d      = '0;
          inp_d       = '0;
          field_d     = '0;
          cfg_error_d = 1'b0;
        end
      end
      READ_TYPE: begin
        if (beat) begin
          if (bit_cnt_q == CNT_W'(SIGNAL_TYPE_W - 1)) begin
            type_we    = 1'b1;
            cur_type_d = t_input_type'(field_val[SIGNAL_TYPE_W-1:0]);
            bit_cnt_d  = '0;
            field_d    = '0;
            state_d    = READ_INDEX;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            field_d   = field_val;
          end
        end
      end
      READ_INDEX: begin
        if (beat) begin
          if (bit_cnt_q == CNT_W'(SIGNAL_INDEX_W - 1)) begin
            idx_we    = 1'b1;
            if (idx_out_of_range(cur_type_q, field_val)) cfg_error_d = 1'b1;
            bit_cnt_d = '0;
            field_d   = '0;
            if (inp_q == INP_W'(LUT_WIDTH - 1)) begin
              inp_d   = '0;
              state_d = READ_TT;
            end else begin
              inp_d   = inp_q + 1'b1;
              state_d = READ_TYPE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            field_d   = field_val;
          end
        end
      end
      READ_TT: begin
        if (beat) begin
          tt_we = 1'b1;
          if (bit_cnt_q == CNT_W'(TT_BITS - 1)) begin
            bit_cnt_d = '0;
`ifdef CLB_OUTPUT_FF_EN
            state_d   = READ_MODE;
`else
            lane_end  = 1'b1;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef CLB_OUTPUT_FF_EN
      READ_MODE: begin
        if (beat) begin
          mode_we  = 1'b1;
          lane_end = 1'b1;
        end
      end
`endif
      default: state_d = state_q;
    endcase

    if (lane_end) begin
      if (lane_q == LANE_W'(NUM_LUTS - 1)) begin
        last_bit = 1'b1;
        state_d  = CONFIGURED;
      end else begin
        lane_d  = lane_q + 1'b1;
        state_d = READ_TYPE;
      end
    end

    // tlast must mark exactly the final bit of the whole stream.
    if (beat && (cfg_bitstream.tlast != last_bit)) begin
      state_d     = ERROR;
      cfg_error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= UNCFG;
      bit_cnt_q   <= '0;
      lane_q      <= '0;
      inp_q       <= '0;
      field_q     <= '0;
      cur_type_q  <= CONST0;
      cfg_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      lane_q      <= lane_d;
      inp_q       <= inp_d;
      field_q     <= field_d;
      cur_type_q  <= cur_type_d;
      cfg_error_q <= cfg_error_d;
    end
  end

  for (genvar gi = 0; gi < NUM_LUTS; gi++) begin : g_lane
    clb_lut_lane #(
      .NUM_LUTS              (NUM_LUTS),
      .LUT_WIDTH             (LUT_WIDTH),
      .NUM_NEIGHBOUR_SIGNALS (NUM_NEIGHBOUR_SIGNALS),
      .NUM_IO_SIGNALS        (NUM_IO_SIGNALS),
      .INP_W                 (INP_W)
    ) u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (clr),
      .sel        (lane_q == LANE_W'(gi)),
      .type_we    (type_we),
      .idx_we     (idx_we),
      .tt_we      (tt_we),
      .mode_we    (mode_we),
      .wr_inp     (inp_q),
      .wr_val     (field_val),
      .tt_addr    (bit_cnt_q[LUT_WIDTH-1:0]),
      .wr_bit     (bit_in),
      .run_en     (run & cfg_done),
      .neighbours (run_in_neighbours),
      .io         (run_in_io),
      .fb         (q_all),
      .q          (q_all[gi]),
      .lane_out   (lane_out[gi])
    );
  end

endmodule

// File: tb/tb_clb_cluster.sv
// Scoreboard bench for clb_cluster; tracks CLB_OUTPUT_FF_EN to size the stream.
module tb_clb_cluster;

  localparam int NL = 2;
  localparam int LW = 4;
  localparam int NN = 8;
  localparam int NI = 4;
  localparam int TT = 16;
`ifdef CLB_OUTPUT_FF_EN
  localparam int LANE_BITS = LW * 10 + TT + 1;
`else
  localparam int LANE_BITS = LW * 10 + TT;
`endif
  localparam int TOTAL = NL * LANE_BITS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg = 1'b0;
  logic          run = 1'b0;
  logic [NN-1:0] nb = '0;
  logic [NI-1:0] io = '0;
  logic [NL-1:0] run_out;
  logic          cfg_done;
  logic          cfg_error;

  axi_stream_if #(.DATA_W(8)) bs ();

  always #5 clk = ~clk;

  clb_cluster #(
    .NUM_LUTS              (NL),
    .LUT_WIDTH             (LW),
    .NUM_NEIGHBOUR_SIGNALS (NN),
    .NUM_IO_SIGNALS        (NI)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .cfg               (cfg),
    .cfg_bitstream     (bs),
    .run               (run),
    .run_in_neighbours (nb),
    .run_in_io         (io),
    .run_out           (run_out),
    .cfg_done          (cfg_done),
    .cfg_error         (cfg_error)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Config being sent (c_*) and config the model believes is loaded (m_*).
  logic [1:0]    c_type [NL][LW];
  logic [7:0]    c_idx  [NL][LW];
  logic [TT-1:0] c_tt   [NL];
  logic          c_mode [NL];
  logic [1:0]    m_type [NL][LW];
  logic [7:0]    m_idx  [NL][LW];
  logic [TT-1:0] m_tt   [NL];
  logic          m_mode [NL];
  logic          m_q    [NL];
  logic          m_done;
  logic          m_err;

  typedef struct {
    string         tag;
    logic [NL-1:0] out;
    logic          done;
    logic          err;
  } exp_t;
  exp_t sb[$];
  logic sbits[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic src_bit(input logic [1:0] t, input int idx);
    case (t)
      2'd0:    return (idx < NN) ? nb[idx] : 1'b0;
      2'd1:    return (idx < NI) ? io[idx] : 1'b0;
      2'd2:    return (idx < NL) ? m_q[idx] : 1'b0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic model_f(input int k);
    int addr = 0;
    for (int i = 0; i < LW; i++)
      if (src_bit(m_type[k][i], int'(m_idx[k][i]))) addr += (1 << i);
    return m_tt[k][addr];
  endfunction

  function automatic logic [NL-1:0] model_out();
    logic [NL-1:0] v = '0;
    if (m_done) begin
      for (int k = 0; k < NL; k++) begin
`ifdef CLB_OUTPUT_FF_EN
        v[k] = m_mode[k] ? m_q[k] : model_f(k);
`else
        v[k] = model_f(k);
`endif
      end
    end
    return v;
  endfunction

  function automatic logic stream_has_bad_idx();
    int lim;
    for (int k = 0; k < NL; k++)
      for (int i = 0; i < LW; i++) begin
        lim = (c_type[k][i] == 2'd0) ? NN : (c_type[k][i] == 2'd1) ? NI : NL;
        if (c_type[k][i] != 2'd3 && int'(c_idx[k][i]) >= lim) return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < NL; k++) begin
      for (int i = 0; i < LW; i++) begin
        m_type[k][i] = 2'd3;
        m_idx[k][i]  = 8'd0;
      end
      m_tt[k]   = '0;
      m_mode[k] = 1'b0;
      m_q[k]    = 1'b0;
    end
    m_done = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic c_clear();
    for (int k = 0; k < NL; k++) begin
      for (int i = 0; i < LW; i++) begin
        c_type[k][i] = 2'd3;
        c_idx[k][i]  = 8'd0;
      end
      c_tt[k]   = '0;
      c_mode[k] = 1'b0;
    end
  endtask

  task automatic tick();
    logic nq [NL];
    for (int k = 0; k < NL; k++) nq[k] = (run && m_done) ? model_f(k) : m_q[k];
    @(posedge clk);
    for (int k = 0; k < NL; k++) m_q[k] = nq[k];
    #1;
  endtask

  task automatic sample(input string tag);
    exp_t e;
    e.tag  = tag;
    e.out  = model_out();
    e.done = m_done;
    e.err  = m_err;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    check_val({e.tag, ".run_out"}, 32'(run_out), 32'(e.out));
    check_val({e.tag, ".cfg_done"}, 32'(cfg_done), 32'(e.done));
    check_val({e.tag, ".cfg_error"}, 32'(cfg_error), 32'(e.err));
    $display("txn %-16s run_out=%b cfg_done=%b cfg_error=%b", e.tag, run_out, cfg_done, cfg_error);
  endtask

  task automatic build_stream();
    sbits.delete();
    for (int k = 0; k < NL; k++) begin
      for (int i = 0; i < LW; i++) begin
        for (int b = 0; b < 2; b++) sbits.push_back(c_type[k][i][b]);
        for (int b = 0; b < 8; b++) sbits.push_back(c_idx[k][i][b]);
      end
      for (int b = 0; b < TT; b++) sbits.push_back(c_tt[k][b]);
`ifdef CLB_OUTPUT_FF_EN
      sbits.push_back(c_mode[k]);
`endif
    end
  endtask

  task automatic load(input int tlast_at, input int n_send, input int stall_at, input int rst_at);
    int   i = 0;
    int   guard = 0;
    logic hs;
    logic stalled = 1'b0;
    logic did_rst = 1'b0;
    build_stream();
    run = 1'b0;
    cfg = 1'b1;
    tick();
    cfg = 1'b0;
    for (int k = 0; k < NL; k++) m_q[k] = 1'b0;
    m_done = 1'b0;
    m_err  = 1'b0;
    while (i < n_send && guard < 2000) begin
      guard++;
      if (i == rst_at) begin
        rst_n = 1'b0;
        model_clear();
        sample("midstream_rst");
        check_val("midstream_rst.tready", 32'(bs.tready), 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        bs.tvalid = 1'b0;
        did_rst   = 1'b1;
        break;
      end
      if (i == stall_at && !stalled) begin
        stalled   = 1'b1;
        bs.tvalid = 1'b0;
        repeat (20) tick();
        check_val("stall.tready", 32'(bs.tready), 32'd1);
      end
      bs.tvalid = 1'b1;
      bs.tdata  = {7'b0, sbits[i]};
      bs.tlast  = (i == tlast_at);
      hs        = bs.tready;
      tick();
      if (hs) i++;
    end
    bs.tvalid = 1'b0;
    bs.tlast  = 1'b0;
    if (!did_rst) begin
      check_val("load.bits_accepted", 32'(i), 32'(n_send));
      if (n_send == TOTAL && tlast_at == TOTAL - 1) begin
        m_type = c_type;
        m_idx  = c_idx;
        m_tt   = c_tt;
        m_mode = c_mode;
        m_done = 1'b1;
        m_err  = stream_has_bad_idx();
      end else begin
        m_done = 1'b0;
        m_err  = 1'b1;
      end
    end
  endtask

  task automatic setup_cfg_a();
    c_clear();
    c_type[0][0] = 2'd1; c_idx[0][0] = 8'd0;
    c_type[0][1] = 2'd1; c_idx[0][1] = 8'd1;
    c_tt[0]      = 16'h0008;
    c_mode[0]    = 1'b0;
    c_type[1][0] = 2'd2; c_idx[1][0] = 8'd1;
    c_tt[1]      = 16'h0001;
    c_mode[1]    = 1'b1;
  endtask

  task automatic and2_and_toggle(input string pfx);
    io = 4'b0011; sample({pfx, ".and2_11"});
    io = 4'b0001; sample({pfx, ".and2_01"});
    io = 4'b0010; sample({pfx, ".and2_10"});
    run = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      sample($sformatf("%s.toggle%0d", pfx, c));
    end
    run = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      sample($sformatf("%s.hold%0d", pfx, c));
    end
  endtask

  initial begin
    bs.tvalid = 1'b0;
    bs.tdata  = '0;
    bs.tlast  = 1'b0;
    model_clear();
    c_clear();
    repeat (2) @(posedge clk);
    #1;
    sample("reset");
    check_val("reset.tready", 32'(bs.tready), 32'd0);
    rst_n = 1'b1;
    tick();

    setup_cfg_a();
    load(TOTAL - 1, TOTAL, -1, -1);
    sample("cfg_a.loaded");
    and2_and_toggle("plain");

    load(50, 51, -1, -1);
    sample("early_tlast");
    io = 4'b0011;
    sample("early_tlast.io11");
    check_val("early_tlast.tready", 32'(bs.tready), 32'd0);

    load(TOTAL - 1, TOTAL, -1, -1);
    sample("reload");

    c_clear();
    c_type[0][0] = 2'd0; c_idx[0][0] = 8'd9;
    c_type[0][1] = 2'd0; c_idx[0][1] = 8'd2;
    c_tt[0]      = 16'h000E;
    load(TOTAL - 1, TOTAL, -1, -1);
    sample("bad_idx.loaded");
    nb = 8'hFF; sample("bad_idx.nbFF");
    nb = 8'h04; sample("bad_idx.nb04");
    nb = 8'h00; sample("bad_idx.nb00");
    nb = 8'hFB; sample("bad_idx.nbFB");

    setup_cfg_a();
    load(TOTAL - 1, TOTAL, 30, -1);
    sample("stall.loaded");
    and2_and_toggle("stall");

    load(TOTAL - 1, TOTAL, -1, 60);
    bs.tvalid = 1'b1;
    bs.tdata  = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_val("uncfg.tready", 32'(bs.tready), 32'd0);
    end
    bs.tvalid = 1'b0;
    sample("after_rst");

    load(TOTAL - 1, TOTAL, -1, -1);
    sample("final.loaded");
    io = 4'b0011;
    sample("final.and2_11");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
